// File: rtl/accel_pkg.sv
// accel_pkg: definitions shared across the accelerator.
//   feed_state_e  - feed scheduler sequence states
//   DEF_NUM_ROWS  - default number of array rows / row buffers
//   DEF_BUFFER_SIZE - default depth of each row buffer
//   feed_cnt_w()  - width of the feed counter for a given geometry
//   CNT_W         - feed counter width for the default geometry
package accel_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FEED,
    DRAIN,
    DONE
  } feed_state_e;

  localparam int unsigned DEF_NUM_ROWS    = 4;
  localparam int unsigned DEF_BUFFER_SIZE = 16;

  // The counter reaches at most BUFFER_SIZE+NUM_ROWS-2, so this width never wraps.
  function automatic int unsigned feed_cnt_w(input int unsigned rows, input int unsigned size);
    return $clog2(rows + size);
  endfunction

  localparam int unsigned CNT_W = feed_cnt_w(DEF_NUM_ROWS, DEF_BUFFER_SIZE);

endpackage

// File: rtl/fifo_feed_scheduler_if.sv
// fifo_feed_scheduler_if: control/status bundle of the row-buffer feed scheduler.
//   start, len, abort        - requester side: start handshake, element count, abort
//   ready, busy, done        - sequence status
//   inject, bubble           - commands to the row buffers (load all / pop row r)
//   data_valid               - row r buffer output valid this cycle
// Modports: master = requester/consumer, slave = scheduler.
interface fifo_feed_scheduler_if
  import accel_pkg::*;
#(
  parameter int unsigned NUM_ROWS = DEF_NUM_ROWS,
  parameter int unsigned LEN_W    = 5
);

  logic                start;
  logic [LEN_W-1:0]    len;
  logic                abort;
  logic                ready;
  logic                busy;
  logic                inject;
  logic [NUM_ROWS-1:0] bubble;
  logic [NUM_ROWS-1:0] data_valid;
  logic                done;

  modport master (
    output start, len, abort,
    input  ready, busy, inject, bubble, data_valid, done
  );

  modport slave (
    input  start, len, abort,
    output ready, busy, inject, bubble, data_valid, done
  );

endinterface

// File: rtl/fifo_feed_scheduler.sv
// fifo_feed_scheduler: sequences a bank of NUM_ROWS row buffers feeding the
// systolic array. An accepted start issues one inject (load all buffers), then
// per-row pops skewed by one cycle per row so operands enter diagonally.
// data_valid tracks the buffers' registered outputs; done pulses at the end.
// Ports:
//   clk  - clock, all logic on posedge
//   rst  - synchronous active-high reset
//   ctrl - fifo_feed_scheduler_if.slave (start/len/abort in; ready/busy/
//          inject/bubble/data_valid/done out)
module fifo_feed_scheduler
  import accel_pkg::*;
#(
  parameter int unsigned NUM_ROWS    = DEF_NUM_ROWS,
  parameter int unsigned BUFFER_SIZE = DEF_BUFFER_SIZE,
  parameter int unsigned LEN_W       = 5
) (
  input logic                   clk,
  input logic                   rst,
  fifo_feed_scheduler_if.slave  ctrl
);

  localparam int unsigned CW = feed_cnt_w(NUM_ROWS, BUFFER_SIZE);

  feed_state_e         state_q, state_d;
  logic [CW-1:0]       t_q, t_d;
  logic [CW-1:0]       len_q, len_d;
  logic [NUM_ROWS-1:0] dv_q, dv_d;
  logic [NUM_ROWS-1:0] bubble;
  logic [CW-1:0]       t_end;
  logic [CW-1:0]       len_clamp;
  logic                feeding;
  logic                abort_hit;

  assign feeding   = (state_q == FEED);
  assign abort_hit = ctrl.abort && (state_q != IDLE);
  // Last counter value of the feed window; only meaningful with len_q >= 1.
  assign t_end     = len_q + CW'(NUM_ROWS) - CW'(2);
  assign len_clamp = (32'(ctrl.len) > BUFFER_SIZE) ? CW'(BUFFER_SIZE) : CW'(ctrl.len);

  // Row r pops while t is in [r, r+L): a one-cycle skew per row.
  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    localparam logic [CW:0] ROW = (CW+1)'(r);
    logic [CW:0] t_x;
    logic [CW:0] hi;
    assign t_x       = {1'b0, t_q};
    assign hi        = ROW + {1'b0, len_q};
    assign bubble[r] = feeding && (t_x >= ROW) && (t_x < hi);
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    len_d   = len_q;
    case (state_q)
      IDLE: begin
        if (ctrl.start) begin
          len_d   = len_clamp;
          state_d = LOAD;
        end
      end
      LOAD: begin
        t_d     = '0;
        state_d = (len_q == '0) ? DONE : FEED;
      end
      FEED: begin
        if (t_q == t_end) state_d = DRAIN;
        else              t_d     = t_q + CW'(1);
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_hit) state_d = IDLE;
    dv_d = abort_hit ? '0 : bubble;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      t_q     <= '0;
      len_q   <= '0;
      dv_q    <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      len_q   <= len_d;
      dv_q    <= dv_d;
    end
  end

  always_comb begin
    ctrl.ready      = (state_q == IDLE);
    ctrl.busy       = (state_q != IDLE);
    ctrl.inject     = (state_q == LOAD);
    ctrl.done       = (state_q == DONE);
    ctrl.bubble     = bubble;
    ctrl.data_valid = dv_q;
  end

endmodule

// File: tb/tb_fifo_feed_scheduler.sv
// tb_fifo_feed_scheduler: directed self-checking bench for fifo_feed_scheduler
// with four modelled row buffers to observe the diagonal operand order.
module tb_fifo_feed_scheduler;

  localparam int unsigned S = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_feed_scheduler_if #(.NUM_ROWS(S), .LEN_W(5)) bus ();

  fifo_feed_scheduler #(
    .NUM_ROWS   (S),
    .BUFFER_SIZE(16),
    .LEN_W      (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .ctrl(bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Row buffer r holds r*16+i; inject reloads, bubble pops into a registered output.
  logic [7:0]  fifo_out [S];
  int unsigned pop_idx  [S];
  always @(posedge clk) begin
    for (int unsigned r = 0; r < S; r++) begin
      if (bus.inject) pop_idx[r] <= 0;
      else if (bus.bubble[r]) begin
        fifo_out[r] <= 8'(r * 16 + pop_idx[r]);
        pop_idx[r]  <= pop_idx[r] + 1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {ready, busy, inject, done, bubble[3:0], data_valid[3:0]}
  function automatic logic [11:0] obs();
    return {bus.ready, bus.busy, bus.inject, bus.done, bus.bubble, bus.data_valid};
  endfunction

  localparam logic [11:0] IDLE_VEC = 12'h800;

  // Expected outputs at cycle k after the accept edge, from the cycle windows.
  function automatic logic [11:0] exp_vec(input int unsigned k, input int unsigned leff);
    int unsigned dc;
    logic [S-1:0] bb, dv;
    logic bsy;
    dc  = (leff == 0) ? 2 : leff + S + 2;
    bsy = (k >= 1) && (k <= dc);
    for (int unsigned r = 0; r < S; r++) begin
      bb[r] = (leff != 0) && (k >= 2 + r) && (k <= 1 + r + leff);
      dv[r] = (leff != 0) && (k >= 3 + r) && (k <= 2 + r + leff);
    end
    return {!bsy, bsy, (k == 1), (k == dc), bb, dv};
  endfunction

  task automatic run_seq(input logic [4:0] len_v, input int unsigned leff,
                         input int unsigned abort_at, input int unsigned pulse_at,
                         input bit chk_fifo, input bit hold);
    int unsigned dc;
    logic [11:0] e;
    dc = (leff == 0) ? 2 : leff + S + 2;
    bus.start = 1'b1;
    bus.len   = len_v;
    tick();
    if (!hold) bus.start = 1'b0;
    bus.len = 5'd1;
    for (int unsigned k = 1; k <= dc + 1; k++) begin
      e = exp_vec(k, leff);
      check_eq($sformatf("L%0d_c%0d", leff, k), 32'(obs()), 32'(e));
      if (chk_fifo) begin
        for (int unsigned r = 0; r < S; r++)
          if (e[r]) check_eq($sformatf("diag_r%0d_c%0d", r, k), 32'(fifo_out[r]),
                             32'(r * 16 + k - 3 - r));
      end
      if (k == abort_at) begin
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check_eq("abort_next", 32'(obs()), 32'(IDLE_VEC));
        return;
      end
      if (k == pulse_at) begin
        bus.start = 1'b1;
        bus.len   = 5'd0;
      end else if (!hold) begin
        bus.start = 1'b0;
      end
      if (k <= dc) tick();
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.len   = '0;
    bus.abort = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    check_eq("reset", 32'(obs()), 32'(IDLE_VEC));
    rst = 1'b0;

    // abort while idle does nothing
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_eq("idle_abort", 32'(obs()), 32'(IDLE_VEC));

    // len=3 with buffer contents checked, start pulse during FEED ignored
    run_seq(5'd3, 3, 0, 3, 1'b1, 1'b0);
    // len=0
    run_seq(5'd0, 0, 0, 0, 1'b0, 1'b0);
    // len=20 clamps to 16
    run_seq(5'd20, 16, 0, 0, 1'b0, 1'b0);
    // abort at cycle 4, then a normal sequence
    run_seq(5'd3, 3, 4, 0, 1'b0, 1'b0);
    run_seq(5'd3, 3, 0, 0, 1'b1, 1'b0);

    // start and abort together in IDLE: start wins
    bus.start = 1'b1;
    bus.len   = 5'd2;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check_eq("start_abort_idle", 32'(obs()), 32'(exp_vec(1, 2)));
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_eq("start_abort_clean", 32'(obs()), 32'(IDLE_VEC));

    // start held high: second accept only from the IDLE cycle after done
    run_seq(5'd2, 2, 0, 0, 1'b0, 1'b1);
    tick();
    check_eq("hold_second_accept", 32'(obs()), 32'(exp_vec(1, 1)));
    bus.start = 1'b0;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_eq("hold_clean", 32'(obs()), 32'(IDLE_VEC));

    // rst at cycle 3 (with abort also high) -> reset values at cycle 4
    bus.start = 1'b1;
    bus.len   = 5'd3;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    check_eq("pre_rst_c3", 32'(obs()), 32'(exp_vec(3, 3)));
    rst       = 1'b1;
    bus.abort = 1'b1;
    tick();
    rst       = 1'b0;
    bus.abort = 1'b0;
    check_eq("rst_mid_c4", 32'(obs()), 32'(IDLE_VEC));
    tick();
    check_eq("rst_mid_after", 32'(obs()), 32'(IDLE_VEC));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
